// File: rtl/rv_bus_arbiter.sv
// rv_bus_arbiter: shares one 32-bit memory port between instruction fetch and load/store.
// Latency: one cycle from request to o_mem_cyc; acks are combinational from i_mem_ack.
// Backpressure: the grant is held until i_mem_ack; load/store has priority, but fetch
//   is forced in after LS_MAX_CONSEC back-to-back load/store grants.
// Ports: i_clk/i_reset (sync, active-high); i_if_* / o_if_* fetch side (halfword address,
//   word reads); i_ls_* / o_ls_* load/store side; o_mem_* / i_mem_* memory port.
// Optional macro RV_ARB_TIMEOUT_EN adds an 8-bit watchdog and the o_bus_err pulse output.
module rv_bus_arbiter #(
  parameter int IADDR_SPACE_BITS = 16,
  parameter int LS_MAX_CONSEC    = 4,
  parameter int TIMEOUT_CYCLES   = 255
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_if_cyc,
  input  logic [IADDR_SPACE_BITS-1:1] i_if_addr,
  output logic                        o_if_ack,
  output logic [31:0]                 o_if_data,
  input  logic                        i_ls_cyc,
  input  logic                        i_ls_we,
  input  logic [3:0]                  i_ls_sel,
  input  logic [31:0]                 i_ls_addr,
  input  logic [31:0]                 i_ls_wdata,
  output logic                        o_ls_ack,
  output logic [31:0]                 o_ls_rdata,
  output logic                        o_mem_cyc,
  output logic                        o_mem_we,
  output logic [3:0]                  o_mem_sel,
  output logic [31:0]                 o_mem_addr,
  output logic [31:0]                 o_mem_wdata,
  input  logic                        i_mem_ack,
  input  logic [31:0]                 i_mem_rdata
`ifdef RV_ARB_TIMEOUT_EN
  ,
  output logic                        o_bus_err
`endif
);

  typedef enum logic [1:0] {IDLE, GNT_IF, GNT_LS} state_t;

  localparam logic [3:0] LS_MAX = 4'(LS_MAX_CONSEC);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        done;       // current transaction completes this cycle
  logic        forced;     // completion forced by the watchdog
  logic [31:0] cmpl_data;  // data returned to the requester on completion
  logic [31:0] if_byte_addr;

  // Fetch address bit 1 selects a halfword inside the word; the memory port is word-wide.
  logic unused_cfg;
  assign unused_cfg = ^{i_if_addr[1], 8'(TIMEOUT_CYCLES)};

  always_comb begin
    if_byte_addr = '0;
    if_byte_addr[IADDR_SPACE_BITS-1:2] = i_if_addr[IADDR_SPACE_BITS-1:2];
  end

`ifdef RV_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);
  logic [7:0] wd;

  assign forced    = (state != IDLE) && !i_mem_ack && (wd == TO_LIMIT);
  assign o_bus_err = forced && !i_reset;

  // Every completion is a grant change (new transaction), so clearing on done covers it.
  always_ff @(posedge i_clk) begin
    if (i_reset || state == IDLE || done) begin
      wd <= 8'd0;
    end else if (wd != 8'hFF) begin
      wd <= wd + 8'd1;
    end
  end
`else
  assign forced = 1'b0;
`endif

  // Reset blocks completion so an ack arriving around reset never reaches a requester.
  assign done      = (state != IDLE) && !i_reset && (i_mem_ack || forced);
  assign cmpl_data = i_mem_ack ? i_mem_rdata : 32'hFFFF_FFFF;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = i_if_cyc ? cnt : 4'd0;
    o_mem_cyc   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_sel   = 4'h0;
    o_mem_addr  = 32'h0;
    o_mem_wdata = 32'h0;
    o_if_ack    = 1'b0;
    o_ls_ack    = 1'b0;

    case (state)
      IDLE: begin
        if (i_ls_cyc) begin
          state_nxt = GNT_LS;
        end else if (i_if_cyc) begin
          state_nxt = GNT_IF;
        end
      end
      GNT_IF: begin
        o_mem_cyc  = 1'b1;
        o_mem_sel  = 4'hF;
        o_mem_addr = if_byte_addr;
        if (done) begin
          o_if_ack = i_if_cyc;
          cnt_nxt  = 4'd0;
        end
      end
      GNT_LS: begin
        o_mem_cyc   = 1'b1;
        o_mem_we    = i_ls_we;
        o_mem_sel   = i_ls_sel;
        o_mem_addr  = i_ls_addr;
        o_mem_wdata = i_ls_wdata;
        if (done) begin
          o_ls_ack = i_ls_cyc;
          if (i_if_cyc && cnt != LS_MAX) begin
            cnt_nxt = cnt + 4'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Re-arbitrate on the completing edge with live request levels. The limit test
    // includes the grant just completing, so exactly LS_MAX_CONSEC load/store grants
    // run back-to-back before a waiting fetch gets its turn.
    if (done) begin
      if (i_ls_cyc && !(i_if_cyc && cnt_nxt == LS_MAX)) begin
        state_nxt = GNT_LS;
      end else if (i_if_cyc) begin
        state_nxt = GNT_IF;
      end else if (i_ls_cyc) begin
        state_nxt = GNT_LS;
      end else begin
        state_nxt = IDLE;
      end
    end
  end

  assign o_if_data  = o_if_ack ? cmpl_data : 32'h0;
  assign o_ls_rdata = o_ls_ack ? cmpl_data : 32'h0;

endmodule
